// File: rtl/uart_tx_sched_if.sv
// Request/UART-TX signal bundle for the UART transmit scheduler.
// master: the scheduler itself; slave: the requesters and UART TX around it.
interface uart_tx_sched_if;
    logic        res_trigger;
    logic [15:0] res_data;
    logic        echo_valid;
    logic [7:0]  echo_data;
    logic        echo_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        busy;
    logic        res_overflow;
    logic [2:0]  state_dbg;

    modport master (
        input  res_trigger,
        input  res_data,
        input  echo_valid,
        input  echo_data,
        input  tx_busy,
        output echo_ready,
        output tx_start,
        output tx_data,
        output busy,
        output res_overflow,
        output state_dbg
    );

    modport slave (
        output res_trigger,
        output res_data,
        output echo_valid,
        output echo_data,
        output tx_busy,
        input  echo_ready,
        input  tx_start,
        input  tx_data,
        input  busy,
        input  res_overflow,
        input  state_dbg
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Shares one UART TX byte transmitter between the 16-bit ALU result (LSB then MSB)
// and a single-byte echo source; results win, every byte is followed by a fixed gap.
module uart_tx_sched #(
    parameter int unsigned INTER_BYTE_DELAY = 1000000,
    parameter int unsigned ACK_TIMEOUT      = 16
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.master bus
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_GAP       = 3'd4;

    localparam logic [1:0] SEL_ECHO    = 2'd0;
    localparam logic [1:0] SEL_RES_LSB = 2'd1;
    localparam logic [1:0] SEL_RES_MSB = 2'd2;

    localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);
    localparam logic [32:0] GAP_LEN  = {1'b0, 32'(INTER_BYTE_DELAY)};

    logic [2:0]  state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] timer_q, timer_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] res_buf_q, res_buf_d;
    logic        res_pend_q, res_pend_d;
    logic        res_overflow_q, res_overflow_d;

    logic        echo_take;
    logic        res_release;
    logic        res_accept;
    logic [31:0] timer_inc;
    logic        gap_done;

    // The MSB issue cycle frees the buffer, so a trigger in that same cycle is taken.
    always_comb begin
        res_release    = (state_q == ST_ISSUE) && (sel_q == SEL_RES_MSB);
        res_accept     = bus.res_trigger && (!res_pend_q || res_release);
        res_pend_d     = res_accept || (res_pend_q && !res_release);
        res_buf_d      = res_accept ? bus.res_data : res_buf_q;
        res_overflow_d = res_overflow_q || (bus.res_trigger && res_pend_q && !res_release);
    end

    assign timer_inc = timer_q + 32'd1;
    // 33-bit compare so a zero delay still gives a one-cycle gap without wrapping.
    assign gap_done  = ({1'b0, timer_q} + 33'd1) >= GAP_LEN;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        tx_data_d = tx_data_q;
        echo_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (res_pend_q) begin
                    sel_d     = SEL_RES_LSB;
                    tx_data_d = res_buf_q[7:0];
                    state_d   = ST_ISSUE;
                end else if (bus.echo_valid) begin
                    echo_take = 1'b1;
                    sel_d     = SEL_ECHO;
                    tx_data_d = bus.echo_data;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
                timer_d = '0;
            end
            ST_WAIT_ACK: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                    timer_d = '0;
                end else if (timer_q == ACK_LAST) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_GAP;
                    timer_d = '0;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    timer_d = '0;
                    if (sel_q == SEL_RES_LSB) begin
                        sel_d     = SEL_RES_MSB;
                        tx_data_d = res_buf_q[15:8];
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            sel_q          <= SEL_ECHO;
            timer_q        <= '0;
            tx_data_q      <= '0;
            res_buf_q      <= '0;
            res_pend_q     <= 1'b0;
            res_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            timer_q        <= timer_d;
            tx_data_q      <= tx_data_d;
            res_buf_q      <= res_buf_d;
            res_pend_q     <= res_pend_d;
            res_overflow_q <= res_overflow_d;
        end
    end

    assign bus.echo_ready   = echo_take;
    assign bus.tx_start     = (state_q == ST_ISSUE);
    assign bus.tx_data      = tx_data_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.res_overflow = res_overflow_q;
    assign bus.state_dbg    = state_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: gap 8, ack timeout 16, UART TX model busy
// for 20 cycles starting one cycle after tx_start.
module tb_uart_tx_sched;

    localparam int unsigned IBD = 8;
    localparam int unsigned ACK = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_sched_if bus ();

    uart_tx_sched #(
        .INTER_BYTE_DELAY(IBD),
        .ACK_TIMEOUT(ACK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    logic        model_en;
    int unsigned busy_cnt;
    always @(posedge clk) begin
        if (reset) busy_cnt <= 0;
        else if (bus.tx_start && model_en) busy_cnt <= 20;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = (busy_cnt != 0);

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_start(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.tx_start === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.state_dbg === 3'd0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_en = 1'b1;
        bus.res_trigger = 1'b0; bus.res_data = '0;
        bus.echo_valid = 1'b0;  bus.echo_data = '0;
        repeat (3) tick();
        n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); else n_pass++;
        n_checks++; if (bus.echo_ready !== 1'b0) $display("FAIL reset_echo_ready: got %b want 0", bus.echo_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.res_overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.res_overflow); else n_pass++;
        n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL reset_state: got %0d want 0", bus.state_dbg); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_result();
        bit ok, seen_busy;
        int s1, s2, fall;
        bus.res_data = 16'hA55A; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0; bus.res_data = '0;
        n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL res_lat_idle: got state %0d want 0", bus.state_dbg); else n_pass++;
        tick();
        s1 = cyc;
        n_checks++; if (bus.tx_start !== 1'b1) $display("FAIL res_lsb_start: got %b want 1", bus.tx_start); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h5A) $display("FAIL res_lsb_data: got %h want 5a", bus.tx_data); else n_pass++;
        tick();
        n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL res_start_pulse: got %b want 0", bus.tx_start); else n_pass++;
        ok = 1'b0; seen_busy = 1'b0; fall = 0; s2 = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.tx_busy) seen_busy = 1'b1;
            else if (seen_busy && fall == 0) fall = cyc;
            if (bus.tx_start === 1'b1) begin ok = 1'b1; s2 = cyc; break; end
        end
        n_checks++; if (!ok) $display("FAIL res_msb_timeout: got no tx_start want one within 100"); else n_pass++;
        n_checks++; if (s2 - s1 != 30) $display("FAIL res_msb_spacing: got %0d want 30", s2 - s1); else n_pass++;
        n_checks++; if (s2 - fall != 9) $display("FAIL res_msb_after_fall: got %0d want 9", s2 - fall); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'hA5) $display("FAIL res_msb_data: got %h want a5", bus.tx_data); else n_pass++;
        wait_idle(100, ok);
        n_checks++; if (!ok) $display("FAIL res_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
        n_checks++; if (cyc - s2 != 30) $display("FAIL res_idle_time: got %0d want 30", cyc - s2); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL res_busy_after: got %b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_echo();
        bit ok;
        int e, bad;
        tick();
        bus.echo_data = 8'h3C; bus.echo_valid = 1'b1;
        #1;
        n_checks++; if (bus.echo_ready !== 1'b1) $display("FAIL echo_ready_idle: got %b want 1", bus.echo_ready); else n_pass++;
        tick();
        e = cyc;
        n_checks++; if (bus.tx_start !== 1'b1) $display("FAIL echo_start: got %b want 1", bus.tx_start); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h3C) $display("FAIL echo_data: got %h want 3c", bus.tx_data); else n_pass++;
        ok = 1'b0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.state_dbg === 3'd0) begin ok = 1'b1; break; end
            if (bus.echo_ready !== 1'b0) bad++;
        end
        n_checks++; if (!ok) $display("FAIL echo_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL echo_ready_busy: got %0d ready cycles want 0", bad); else n_pass++;
        n_checks++; if (cyc - e != 30) $display("FAIL echo_idle_time: got %0d want 30", cyc - e); else n_pass++;
        n_checks++; if (bus.echo_ready !== 1'b1) $display("FAIL echo_ready_again: got %b want 1", bus.echo_ready); else n_pass++;
        bus.echo_valid = 1'b0;
        #1;
        n_checks++; if (bus.echo_ready !== 1'b0) $display("FAIL echo_ready_novalid: got %b want 0", bus.echo_ready); else n_pass++;
    endtask

    task automatic test_priority();
        bit ok;
        int at;
        logic [7:0] exp_b [3];
        exp_b = '{8'h34, 8'h12, 8'h99};
        tick();
        bus.echo_data = 8'h77; bus.echo_valid = 1'b1;
        tick();
        bus.echo_data = 8'h99;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.state_dbg === 3'd4) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL prio_gap_timeout: got no GAP want GAP within 100"); else n_pass++;
        bus.res_data = 16'h1234; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_start(100, ok, at);
            n_checks++; if (!ok) $display("FAIL prio_start_timeout: byte %0d got none want tx_start", k); else n_pass++;
            n_checks++; if (bus.tx_data !== exp_b[k]) $display("FAIL prio_order: byte %0d got %h want %h", k, bus.tx_data, exp_b[k]); else n_pass++;
        end
        bus.echo_valid = 1'b0;
        wait_idle(100, ok);
        n_checks++; if (!ok) $display("FAIL prio_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
    endtask

    task automatic test_msb_retrigger();
        bit ok;
        int at;
        bus.res_data = 16'h2211; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        wait_start(10, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'h11) $display("FAIL retrig_lsb: got ok=%b data %h want 1/11", ok, bus.tx_data); else n_pass++;
        wait_start(100, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'h22) $display("FAIL retrig_msb: got ok=%b data %h want 1/22", ok, bus.tx_data); else n_pass++;
        bus.res_data = 16'h4433; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        n_checks++; if (bus.res_overflow !== 1'b0) $display("FAIL retrig_overflow: got %b want 0", bus.res_overflow); else n_pass++;
        wait_start(100, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'h33) $display("FAIL retrig_lsb2: got ok=%b data %h want 1/33", ok, bus.tx_data); else n_pass++;
        wait_start(100, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'h44) $display("FAIL retrig_msb2: got ok=%b data %h want 1/44", ok, bus.tx_data); else n_pass++;
        wait_idle(100, ok);
        n_checks++; if (!ok) $display("FAIL retrig_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
    endtask

    task automatic test_overflow();
        bit ok;
        int at;
        bus.res_data = 16'hBEEF; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        wait_start(10, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'hEF) $display("FAIL ovf_lsb: got ok=%b data %h want 1/ef", ok, bus.tx_data); else n_pass++;
        tick(); tick();
        bus.res_data = 16'h1111; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        n_checks++; if (bus.res_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.res_overflow); else n_pass++;
        wait_start(100, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'hBE) $display("FAIL ovf_msb: got ok=%b data %h want 1/be", ok, bus.tx_data); else n_pass++;
        wait_idle(100, ok);
        n_checks++; if (!ok) $display("FAIL ovf_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
        wait_start(60, ok, at);
        n_checks++; if (ok) $display("FAIL ovf_dropped_sent: got tx_start data %h want none", bus.tx_data); else n_pass++;
        n_checks++; if (bus.res_overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.res_overflow); else n_pass++;
    endtask

    task automatic test_no_ack();
        bit ok;
        int s1, s2;
        model_en = 1'b0;
        bus.res_data = 16'h5566; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        wait_start(10, ok, s1);
        n_checks++; if (!ok || bus.tx_data !== 8'h66) $display("FAIL noack_lsb: got ok=%b data %h want 1/66", ok, bus.tx_data); else n_pass++;
        repeat (16) tick();
        n_checks++; if (bus.state_dbg !== 3'd2) $display("FAIL noack_last_wait: got state %0d want 2", bus.state_dbg); else n_pass++;
        tick();
        n_checks++; if (bus.state_dbg !== 3'd4) $display("FAIL noack_to_gap: got state %0d want 4", bus.state_dbg); else n_pass++;
        wait_start(100, ok, s2);
        n_checks++; if (!ok || bus.tx_data !== 8'h55) $display("FAIL noack_msb: got ok=%b data %h want 1/55", ok, bus.tx_data); else n_pass++;
        n_checks++; if (s2 - s1 != 25) $display("FAIL noack_spacing: got %0d want 25", s2 - s1); else n_pass++;
        wait_idle(100, ok);
        n_checks++; if (!ok) $display("FAIL noack_idle_timeout: got no IDLE want IDLE within 100"); else n_pass++;
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int at;
        bus.res_data = 16'h7788; bus.res_trigger = 1'b1;
        tick();
        bus.res_trigger = 1'b0;
        wait_start(10, ok, at);
        n_checks++; if (!ok || bus.tx_data !== 8'h88) $display("FAIL rstmid_lsb: got ok=%b data %h want 1/88", ok, bus.tx_data); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.state_dbg === 3'd3) begin ok = 1'b1; break; end
        end
        n_checks++; if (!ok) $display("FAIL rstmid_wait_done: got no WAIT_DONE want it within 10"); else n_pass++;
        reset = 1'b1;
        bus.res_data = 16'hABCD; bus.res_trigger = 1'b1;
        tick();
        n_checks++; if (bus.state_dbg !== 3'd0) $display("FAIL rstmid_state: got %0d want 0", bus.state_dbg); else n_pass++;
        n_checks++; if (bus.tx_data !== 8'h00) $display("FAIL rstmid_tx_data: got %h want 00", bus.tx_data); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.tx_start !== 1'b0) $display("FAIL rstmid_tx_start: got %b want 0", bus.tx_start); else n_pass++;
        n_checks++; if (bus.res_overflow !== 1'b0) $display("FAIL rstmid_overflow: got %b want 0", bus.res_overflow); else n_pass++;
        reset = 1'b0;
        bus.res_trigger = 1'b0;
        wait_start(80, ok, at);
        n_checks++; if (ok) $display("FAIL rstmid_no_start: got tx_start data %h want none", bus.tx_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_result();
        test_echo();
        test_priority();
        test_msb_retrigger();
        test_overflow();
        test_no_ack();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish before 1000000 ns");
        $fatal(1);
    end

endmodule
